// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int LANE_W    = 2;
  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is a
// combinational pulse on the strobe that delivers the 4th byte of a word.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(HDR_BYTES - 1);

  logic [LANE_W-1:0] lane_p0;
  logic [23:0]       part_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_p0 <= '0;
    end else if (clear) begin
      lane_p0 <= '0;
    end else if (strobe) begin
      lane_p0 <= lane_p0 + 1'b1;
    end
  end

  // Lower three bytes are held; the 4th is taken straight from the input.
  always_ff @(posedge clk) begin
    if (strobe && !clear) begin
      case (lane_p0)
        2'd0:    part_p0[7:0]   <= byte_in;
        2'd1:    part_p0[15:8]  <= byte_in;
        2'd2:    part_p0[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word_valid = strobe && !clear && (lane_p0 == LAST_LANE);
  assign word       = {byte_in, part_p0};

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the CPU in reset
// until the image is complete. Optional checksum stage: LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   widx_q;
  logic [31:0]       nwords_q;
  logic [31:0]       word;
  logic              word_valid;
  logic              accept;
  logic              last_word;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  assign in_ready  = ((state_q == HDR) || (state_q == DATA) || (state_q == CSUM)) && !reload;
  assign accept    = in_valid && in_ready;
  assign last_word = (32'(widx_q) == (nwords_q - 32'd1));

  word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (reload),
    .strobe     (accept),
    .byte_in    (in_byte),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (reload) begin
      sum_q <= '0;
    end else if (word_valid && state_q == DATA) begin
      sum_q <= sum_q + word;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = HDR;
    end else if (word_valid) begin
      case (state_q)
        HDR: begin
          if (word == 32'd0)
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          else if (word > 32'(MAX_WORDS))
            state_d = ERR;
          else
            state_d = DATA;
        end
        DATA: begin
          if (last_word)
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: state_d = (word == sum_q) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HDR;
      widx_q   <= '0;
      nwords_q <= '0;
    end else begin
      state_q <= state_d;
      if (reload) begin
        widx_q <= '0;
      end else if (word_valid && state_q == HDR) begin
        nwords_q <= word;
      end else if (word_valid && state_q == DATA) begin
        widx_q <= widx_q + 1'b1;
      end
    end
  end

  // Write stage: strobe, address and data registered together on the 4th-byte edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= word_valid && (state_q == DATA);
      if (word_valid && state_q == DATA) begin
        addr_p1  <= widx_q[ADDR_W-1:0];
        wdata_p1 <= word;
      end
    end
  end

  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;

  // Status stage: follows the state register by one edge; reload clears at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cpu_reset <= reload || (state_q != DONE);
      done      <= !reload && (state_q == DONE);
      error     <= !reload && (state_q == ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (both checksum build variants).
module tb_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      in_byte  = 8'h5A;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  // Reload pulse with a competing byte that must not be taken.
  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    #1;
    check("rld_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    check("rld_done", 32'(done), 32'd0);
    check("rld_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rld_error", 32'(error), 32'd0);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_write(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF, a);
    check({tag, "_data"}, (i < wr_data.size()) ? wr_data[i] : 32'hFFFF_FFFF, d);
  endtask

  task automatic basic_load(input string tag, input int maxgap);
    send_word(32'd3, maxgap);
    send_word(32'h0050_0093, maxgap);
    send_word(32'h00A0_0113, maxgap);
    send_word(32'h0000_006F, maxgap);
    check({tag, "_we_last"}, 32'(imem_we), 32'd1);
    check({tag, "_addr_last"}, 32'(imem_addr), 32'd2);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h00F0_0215, maxgap);
`endif
    check({tag, "_done_early"}, 32'(done), 32'd0);
    check({tag, "_cpurst_early"}, 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd3);
    check_write({tag, "_w0"}, 0, 32'd0, 32'h0050_0093);
    check_write({tag, "_w1"}, 1, 32'd1, 32'h00A0_0113);
    check_write({tag, "_w2"}, 2, 32'd2, 32'h0000_006F);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    reload   = 1'b0;
    #12;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    basic_load("basic", 0);

    do_reload();
    send_word(32'd0, 0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'd0, 0);
`endif
    @(posedge clk); #1;
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpurst", 32'(cpu_reset), 32'd0);
    check("empty_nwr", 32'(wr_addr.size()), 32'd0);

    do_reload();
    send_word(32'(MAX_WORDS + 1), 0);
    @(posedge clk); #1;
    check("big_error", 32'(error), 32'd1);
    check("big_cpurst", 32'(cpu_reset), 32'd1);
    check("big_in_ready", 32'(in_ready), 32'd0);
    check("big_done", 32'(done), 32'd0);
    check("big_nwr", 32'(wr_addr.size()), 32'd0);

    do_reload();
    basic_load("stall", 3);

    do_reload();
    send_word(32'd1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reload();
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hDEAD_BEEF, 0);
`endif
    @(posedge clk); #1;
    check("rld_img_done", 32'(done), 32'd1);
    check("rld_img_nwr", 32'(wr_addr.size()), 32'd1);
    check_write("rld_img_w0", 0, 32'd0, 32'hDEAD_BEEF);

`ifdef LOADER_CHECKSUM_EN
    do_reload();
    send_word(32'd2, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0000, 0);
    @(posedge clk); #1;
    check("csum_ok_done", 32'(done), 32'd1);
    check("csum_ok_error", 32'(error), 32'd0);

    do_reload();
    send_word(32'd2, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0001, 0);
    @(posedge clk); #1;
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_cpurst", 32'(cpu_reset), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the RV32I single-cycle core. It receives a framed little-endian byte stream, packs it into 32-bit instruction words, and writes them sequentially into instruction memory. It holds the CPU in reset until the image is complete, then releases it. It is the write side of the memory image that the CPU bench later reads back and checks.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width.
- `MAX_WORDS`, default `1<<ADDR_W`: largest accepted image, in words.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_byte` is valid.
- `in_byte`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `reload`  in  1: one-cycle pulse that restarts loading.
- `imem_we`  out  1: instruction-memory write strobe.
- `imem_addr`  out  ADDR_W: word address.
- `imem_wdata`  out  32: word to write.
- `cpu_reset`  out  1: active-high reset to the CPU top module.
- `done`  out  1: image loaded; CPU running.
- `error`  out  1: frame rejected.

## Operation
- **Frame format:** a 4-byte word count N (LSB first), then N data words of 4 bytes each (LSB first), then an optional 4-byte checksum (see Configuration).
- **Handshake:** a byte is accepted on a rising edge when `in_valid && in_ready`. `in_ready` is combinational: it is 1 in states HDR, DATA and CSUM, and 0 in DONE and ERR.
- **States and transitions:**
  - HDR: collect 4 bytes into N.
    - N == 0: go to DONE (or CSUM when checksum is enabled).
    - N > MAX_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA: collect 4 bytes, then issue a write at word index `widx`, and increment `widx`. After word N-1, go to CSUM when checksum is enabled, otherwise DONE.
  - CSUM: described under Configuration.
  - DONE: `cpu_reset`=0, `done`=1. Further bytes are not accepted.
  - ERR: `cpu_reset`=1, `error`=1. Further bytes are not accepted.
- **Reload:** `reload` in any state returns the block to HDR. It clears the byte lane and `widx`, re-asserts `cpu_reset`, and clears `done` and `error`.
  - `reload` has priority over a byte handshake in the same cycle; that byte is not accepted, so `in_ready` is forced to 0 during `reload`.
- **Arithmetic:** `widx` is ADDR_W+1 bits wide, so no wrap can occur at MAX_WORDS. The byte lane counter is 2 bits and wraps 3 to 0 on each completed word.

## Timing
- **Reset values:** state HDR, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0. `in_ready`=1 once `reset_n` is high.
- **Write latency:** `imem_we` is a registered pulse lasting exactly 1 cycle. It rises on the edge that accepts the 4th byte of a word, with `imem_addr` and `imem_wdata` valid in the same cycle.
- **Release timing:** DONE is entered on that same edge for the last word. `cpu_reset` falls and `done` rises on the next edge, which is 2 edges after the last byte is accepted.
- **Throughput:** one byte per cycle with no bubbles. Back-to-back write pulses are 4 cycles apart.
- **Stream stalls:** when `in_valid` is low mid-word, the partial word is held indefinitely.
- **Reset during operation:** asserting `reset_n` low mid-load aborts immediately to the reset values. Partially written memory is left as is.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the data words, CSUM collects 4 bytes and compares them against the 32-bit wrapping sum of all data words. The header is excluded from the sum.
  - Equal: go to DONE. Different: go to ERR.
  - N == 0 expects a checksum of 0.
- `LOADER_CHECKSUM_EN` undefined:
  - There is no CSUM state and no sum register.
  - DONE follows the last data word (or the header when N == 0).

## Structure
- `prog_loader_pkg` contains:
  - the state enum (HDR, DATA, CSUM, DONE, ERR);
  - the byte-lane width constant;
  - the header length constant (4).
- Sub-module `word_assembler` takes a byte plus a strobe and outputs a 32-bit word plus a `word_valid` pulse. It provides a `clear` input driven by `reload`.
- The FSM, `widx` and checksum logic live in `prog_loader`.

## Test plan
- **Basic load:** stream `03 00 00 00 | 93 00 50 00 | 13 01 a0 00 | 6f 00 00 00` -> writes 0x00500093 to address 0, 0x00A00113 to address 1 and 0x0000006F to address 2; `cpu_reset` falls 2 edges after the last byte; `done`=1.
- **Empty image:** header N=0 (plus checksum `00 00 00 00` when enabled) -> no `imem_we`; `done`=1.
- **Oversized image:** header N = MAX_WORDS+1 -> `error`=1, `cpu_reset` stays 1, `in_ready`=0, no writes.
- **Random stalls:** random `in_valid` gaps during the basic-load image -> identical writes and addresses.
- **Reload:** `reload` asserted after 6 bytes, then a full 1-word image (0xDEADBEEF) -> a single write of 0xDEADBEEF to address 0, with no write from the aborted frame.
- **Checksum (`LOADER_CHECKSUM_EN`):** words 0x00000001 and 0xFFFFFFFF with checksum `00 00 00 00` -> DONE. The same words with checksum `01 00 00 00` -> ERR.
